// File: rtl/pulse_period_monitor_if.sv
// Bundle of the monitored pulse, clear request and all status outputs of pulse_period_monitor.
interface pulse_period_monitor_if #(
  parameter int CBITS = 10
);
  logic             sig;
  logic             clr;
  logic             locked;
  logic             err;
  logic             early;
  logic             miss;
  logic [CBITS-1:0] last_int;
  logic [7:0]       err_cnt;

  modport master (
    output sig, clr,
    input  locked, err, early, miss, last_int, err_cnt
  );

  modport slave (
    input  sig, clr,
    output locked, err, early, miss, last_int, err_cnt
  );
endinterface

// File: rtl/pulse_period_monitor.sv
// Pulse period monitor: checks sig pulse spacing against PERIOD +/- TOL and locks after LOCK_CNT good intervals.
// Optional macro PULSE_MON_STICKY_ERR_EN makes err sticky until rst/clr; otherwise err = early | miss.
module pulse_period_monitor #(
  parameter int PERIOD   = 751,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CBITS    = 10
) (
  input logic clk,
  input logic rst,
  pulse_period_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, LOST} state_t;

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] LO_C  = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] HI_C  = CBITS'(PERIOD + TOL);
  localparam logic [CBITS-1:0] TO_C  = CBITS'(PERIOD + TOL + 1);
  localparam logic [CBITS-1:0] ONE_C = CBITS'(1);
  localparam logic [GBITS-1:0] GLAST = GBITS'(LOCK_CNT - 1);
  localparam logic [GBITS-1:0] GFULL = GBITS'(LOCK_CNT);

  state_t           state, state_nx;
  logic [CBITS-1:0] cnt, cnt_nx;
  logic [GBITS-1:0] gcnt, gcnt_nx;
  logic [CBITS-1:0] last_int_q, last_int_nx;
  logic             early_q, early_nx;
  logic             miss_q, miss_nx;
  logic [7:0]       err_cnt_q;

  logic tracking, pulse, timeout, is_early, is_good;

  assign pulse    = bus.sig;
  assign tracking = (state == ACQ) || (state == LOCKED);
  assign timeout  = tracking && (cnt == TO_C);
  assign is_early = tracking && pulse && !timeout && (cnt < LO_C);
  assign is_good  = tracking && pulse && !timeout && (cnt >= LO_C) && (cnt <= HI_C);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    gcnt_nx     = gcnt;
    last_int_nx = last_int_q;
    early_nx    = 1'b0;
    miss_nx     = 1'b0;
    case (state)
      IDLE, LOST: begin
        if (pulse) begin
          state_nx = ACQ;
          gcnt_nx  = '0;
          cnt_nx   = ONE_C;
        end else begin
          cnt_nx   = '0;
        end
      end
      default: begin
        if (timeout) begin
          // a pulse landing on the timeout cycle still counts as a miss but restarts acquisition
          miss_nx = 1'b1;
          gcnt_nx = '0;
          if (pulse) begin
            state_nx = ACQ;
            cnt_nx   = ONE_C;
          end else begin
            state_nx = (state == LOCKED) ? LOST : IDLE;
            cnt_nx   = '0;
          end
        end else if (is_early) begin
          early_nx    = 1'b1;
          last_int_nx = cnt;
          cnt_nx      = ONE_C;
          gcnt_nx     = '0;
          state_nx    = ACQ;
        end else if (is_good) begin
          last_int_nx = cnt;
          cnt_nx      = ONE_C;
          if (state == ACQ) begin
            if (gcnt == GLAST) begin
              state_nx = LOCKED;
              gcnt_nx  = GFULL;
            end else begin
              gcnt_nx  = gcnt + 1'b1;
            end
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gcnt       <= '0;
      last_int_q <= '0;
      early_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      gcnt       <= gcnt_nx;
      last_int_q <= last_int_nx;
      early_q    <= early_nx;
      miss_q     <= miss_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      err_cnt_q <= '0;
    end else if ((early_nx || miss_nx) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

`ifdef PULSE_MON_STICKY_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      err_q <= 1'b0;
    end else if (early_nx || miss_nx) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = early_q | miss_q;
`endif

  assign bus.locked   = (state == LOCKED);
  assign bus.early    = early_q;
  assign bus.miss     = miss_q;
  assign bus.last_int = last_int_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboard bench for pulse_period_monitor: a timestamp-based reference model predicts every output cycle.
module tb_pulse_period_monitor;

  localparam int P  = 12;
  localparam int T  = 1;
  localparam int L  = 3;
  localparam int CB = 5;
  localparam int LO = P - T;
  localparam int HI = P + T;

  typedef struct packed {
    logic          locked;
    logic          err;
    logic          early;
    logic          miss;
    logic [CB-1:0] last_int;
    logic [7:0]    err_cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  pulse_period_monitor_if #(.CBITS(CB)) bus ();

  pulse_period_monitor #(
    .PERIOD  (P),
    .TOL     (T),
    .LOCK_CNT(L),
    .CBITS   (CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model: timestamps of pulses rather than a running counter
  int cyc        = 0;
  bit m_active   = 0;
  bit m_locked   = 0;
  int m_good     = 0;
  int m_last     = 0;
  int m_last_int = 0;
  int m_errc     = 0;
  bit m_err      = 0;

  task automatic step(input bit s, input bit c, input bit r);
    bit   ev_e, ev_m;
    int   iv;
    obs_t e;
    @(negedge clk);
    bus.sig = s;
    bus.clr = c;
    rst     = r;
    ev_e = 0;
    ev_m = 0;
    if (r) begin
      m_active = 0; m_locked = 0; m_good = 0;
      m_last_int = 0; m_errc = 0; m_err = 0;
    end else begin
      if (!m_active) begin
        if (s) begin
          m_active = 1; m_good = 0; m_last = cyc;
        end
      end else begin
        iv = cyc - m_last;
        if (iv == HI + 1) begin
          ev_m = 1; m_good = 0; m_locked = 0;
          if (s) m_last = cyc;
          else m_active = 0;
        end else if (s) begin
          m_last_int = iv;
          m_last     = cyc;
          if (iv < LO) begin
            ev_e = 1; m_good = 0; m_locked = 0;
          end else if (!m_locked) begin
            m_good++;
            if (m_good == L) m_locked = 1;
          end
        end
      end
      if (c) m_errc = 0;
      else if ((ev_e || ev_m) && m_errc < 255) m_errc++;
`ifdef PULSE_MON_STICKY_ERR_EN
      if (c) m_err = 0;
      else if (ev_e || ev_m) m_err = 1;
`else
      m_err = ev_e | ev_m;
`endif
    end
    e.locked   = m_locked;
    e.err      = m_err;
    e.early    = ev_e;
    e.miss     = ev_m;
    e.last_int = CB'(m_last_int);
    e.err_cnt  = 8'(m_errc);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic gap(input int n);
    repeat (n - 1) step(0, 0, 0);
    step(1, 0, 0);
  endtask

  task automatic rgap(input int n);
    repeat (n - 1) step(0, ($urandom_range(0, 15) == 0), 0);
    step(1, ($urandom_range(0, 15) == 0), 0);
  endtask

  initial begin : monitor
    obs_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.locked   = bus.locked;
        got.err      = bus.err;
        got.early    = bus.early;
        got.miss     = bus.miss;
        got.last_int = bus.last_int;
        got.err_cnt  = bus.err_cnt;
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL outputs @%0t: got locked=%0b err=%0b early=%0b miss=%0b last_int=%0d err_cnt=%0d, expected locked=%0b err=%0b early=%0b miss=%0b last_int=%0d err_cnt=%0d",
                      $time, got.locked, got.err, got.early, got.miss, got.last_int, got.err_cnt,
                      e.locked, e.err, e.early, e.miss, e.last_int, e.err_cnt);
      end
    end
  end

  initial begin : driver
    bus.sig = 1'b0;
    bus.clr = 1'b0;
    rst     = 1'b1;

    repeat (3) step(0, 0, 1);

    // acquire and lock with jittered but in-tolerance intervals
    step(1, 0, 0);
    repeat (8) gap($urandom_range(LO, HI));

    // random intervals spanning early, good and timeout, with occasional clr
    repeat (60) rgap($urandom_range(1, HI + 3));

    // lock, then starve the input to force a miss into LOST
    step(1, 0, 0);
    repeat (L) gap(P);
    repeat (HI + 5) step(0, 0, 0);

    // pulse exactly on the timeout cycle while acquiring
    step(1, 0, 0);
    gap(HI + 1);
    repeat (L) gap(P);

    // back-to-back pulses while locked
    gap(P);
    gap(1);

    // saturate the error counter, miss at saturation, then clear (also clr coincident with an event)
    repeat (300) step(1, 0, 0);
    repeat (HI + 3) step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);

    // reset asserted while locked, with a pulse during reset
    repeat (L) gap(P);
    repeat (3) step(0, 0, 0);
    step(1, 1, 1);
    repeat (P + 5) step(0, 0, 0);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
